// File: rtl/audio_mixer_n_if.sv
// Frame-level port bundle of the N-channel stereo mixer.
// The slave modport is the mixer side and the master modport is the producer/consumer side.
interface audio_mixer_n_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned GAIN_W = 8
);
  logic                       sample_stb_i;
  logic [NUM_CH*IN_W-1:0]     ch_data_i;
  logic [NUM_CH*GAIN_W-1:0]   ch_gain_i;
  logic [NUM_CH*2-1:0]        ch_route_i;
  logic                       mute_i;
  logic                       clear_i;
  logic [OUT_W-1:0]           left_o;
  logic [OUT_W-1:0]           right_o;
  logic                       valid_o;
  logic                       busy_o;
  logic                       clip_l_o;
  logic                       clip_r_o;
  logic                       overrun_o;

  modport slave (
    input  sample_stb_i, ch_data_i, ch_gain_i, ch_route_i, mute_i, clear_i,
    output left_o, right_o, valid_o, busy_o, clip_l_o, clip_r_o, overrun_o
  );

  modport master (
    output sample_stb_i, ch_data_i, ch_gain_i, ch_route_i, mute_i, clear_i,
    input  left_o, right_o, valid_o, busy_o, clip_l_o, clip_r_o, overrun_o
  );
endinterface

// File: rtl/audio_mixer_n.sv
// N-channel stereo mixer: per-channel gain and L/R routing, one channel MAC per cycle,
// then floor-shift back to unity gain and saturate to the output width.
module audio_mixer_n #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned OUT_W  = 16,
  parameter int unsigned GAIN_W = 8
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  audio_mixer_n_if.slave  bus
);

  localparam int unsigned PROD_W   = IN_W + GAIN_W + 1;
  localparam int unsigned ACC_W    = PROD_W + $clog2(NUM_CH);
  localparam int unsigned IDX_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int unsigned SHIFT    = GAIN_W - 1;
  localparam int unsigned LAST_IDX = NUM_CH - 1;

  // Output range expressed at accumulator width for signed comparison.
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'({1'b0, {(OUT_W-1){1'b1}}});
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_SCALE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [IDX_W-1:0]           idx_q, idx_d;
  logic [NUM_CH*IN_W-1:0]     data_q, data_d;
  logic [NUM_CH*GAIN_W-1:0]   gain_q, gain_d;
  logic [NUM_CH*2-1:0]        route_q, route_d;
  logic                       mute_q, mute_d;
  logic signed [ACC_W-1:0]    acc_l_q, acc_l_d;
  logic signed [ACC_W-1:0]    acc_r_q, acc_r_d;
  logic [OUT_W-1:0]           left_q, left_d;
  logic [OUT_W-1:0]           right_q, right_d;
  logic                       valid_q, valid_d;
  logic                       busy_q, busy_d;
  logic                       clip_l_q, clip_l_d;
  logic                       clip_r_q, clip_r_d;
  logic                       overrun_q, overrun_d;

  logic signed [IN_W-1:0]     cur_data_c;
  logic signed [GAIN_W:0]     cur_gain_c;
  logic signed [PROD_W-1:0]   prod_c;
  logic [OUT_W:0]             sat_l_c;
  logic [OUT_W:0]             sat_r_c;

  // Returns {clip, sample}: floor shift back to unity gain, then clamp.
  function automatic logic [OUT_W:0] saturate(input logic signed [ACC_W-1:0] acc);
    logic signed [ACC_W-1:0] shifted;
    shifted = acc >>> SHIFT;
    if (shifted > SAT_MAX) begin
      saturate = {1'b1, SAT_MAX[OUT_W-1:0]};
    end else if (shifted < SAT_MIN) begin
      saturate = {1'b1, SAT_MIN[OUT_W-1:0]};
    end else begin
      saturate = {1'b0, shifted[OUT_W-1:0]};
    end
  endfunction

  // Selected channel's signed product; gain is zero-extended so it is never negative.
  always_comb begin
    cur_data_c = data_q[32'(idx_q) * IN_W +: IN_W];
    cur_gain_c = {1'b0, gain_q[32'(idx_q) * GAIN_W +: GAIN_W]};
    prod_c     = PROD_W'(cur_data_c) * PROD_W'(cur_gain_c);
  end

  assign sat_l_c = saturate(acc_l_q);
  assign sat_r_c = saturate(acc_r_q);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      data_q    <= '0;
      gain_q    <= '0;
      route_q   <= '0;
      mute_q    <= 1'b0;
      acc_l_q   <= '0;
      acc_r_q   <= '0;
      left_q    <= '0;
      right_q   <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      clip_l_q  <= 1'b0;
      clip_r_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      data_q    <= data_d;
      gain_q    <= gain_d;
      route_q   <= route_d;
      mute_q    <= mute_d;
      acc_l_q   <= acc_l_d;
      acc_r_q   <= acc_r_d;
      left_q    <= left_d;
      right_q   <= right_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      clip_l_q  <= clip_l_d;
      clip_r_q  <= clip_r_d;
      overrun_q <= overrun_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    data_d    = data_q;
    gain_d    = gain_q;
    route_d   = route_q;
    mute_d    = mute_q;
    acc_l_d   = acc_l_q;
    acc_r_d   = acc_r_q;
    left_d    = left_q;
    right_d   = right_q;
    valid_d   = 1'b0;
    clip_l_d  = clip_l_q;
    clip_r_d  = clip_r_q;
    overrun_d = overrun_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.sample_stb_i) begin
          data_d  = bus.ch_data_i;
          gain_d  = bus.ch_gain_i;
          route_d = bus.ch_route_i;
          mute_d  = bus.mute_i;
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = S_ACCUM;
        end
      end

      S_ACCUM: begin
        if (route_q[2*idx_q]) begin
          acc_l_d = acc_l_q + ACC_W'(prod_c);
        end
        if (route_q[2*idx_q+1]) begin
          acc_r_d = acc_r_q + ACC_W'(prod_c);
        end
        if (idx_q == IDX_W'(LAST_IDX)) begin
          state_d = S_SCALE;
        end else begin
          idx_d = idx_q + IDX_W'(1);
        end
      end

      S_SCALE: begin
        if (mute_q) begin
          left_d   = '0;
          right_d  = '0;
          clip_l_d = 1'b0;
          clip_r_d = 1'b0;
        end else begin
          left_d   = sat_l_c[OUT_W-1:0];
          right_d  = sat_r_c[OUT_W-1:0];
          clip_l_d = sat_l_c[OUT_W];
          clip_r_d = sat_r_c[OUT_W];
        end
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);

    // A strobe arriving mid-frame is dropped; setting beats a same-cycle clear.
    if (bus.clear_i) begin
      overrun_d = 1'b0;
    end
    if (bus.sample_stb_i && busy_q) begin
      overrun_d = 1'b1;
    end
  end

  assign bus.left_o    = left_q;
  assign bus.right_o   = right_q;
  assign bus.valid_o   = valid_q;
  assign bus.busy_o    = busy_q;
  assign bus.clip_l_o  = clip_l_q;
  assign bus.clip_r_o  = clip_r_q;
  assign bus.overrun_o = overrun_q;

endmodule

// File: tb/tb_audio_mixer_n.sv
// Scoreboard bench for audio_mixer_n: expected frames are queued at each accepted strobe
// and compared, including arrival cycle, whenever valid_o pulses.
module tb_audio_mixer_n;

  localparam int NUM_CH = 4;
  localparam int IN_W   = 16;
  localparam int OUT_W  = 16;
  localparam int GAIN_W = 8;
  localparam int LAT    = NUM_CH + 2;
  localparam longint UNITY = 128;

  typedef struct {
    int cyc;
    int left;
    int right;
    bit clip_l;
    bit clip_r;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   n_checks;
  int   n_pass;
  exp_t sb[$];

  logic [NUM_CH*IN_W-1:0]   d_data;
  logic [NUM_CH*GAIN_W-1:0] d_gain;
  logic [NUM_CH*2-1:0]      d_route;
  logic                     d_mute;

  audio_mixer_n_if #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) bus ();

  audio_mixer_n #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W), .GAIN_W(GAIN_W)) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic longint floor_div(input longint s, input longint d);
    longint q;
    q = s / d;
    if ((s % d) != 0 && s < 0) q = q - 1;
    return q;
  endfunction

  function automatic exp_t model(input logic [NUM_CH*IN_W-1:0] data,
                                 input logic [NUM_CH*GAIN_W-1:0] gain,
                                 input logic [NUM_CH*2-1:0] route,
                                 input logic mute, input int at);
    exp_t   e;
    longint sl = 0;
    longint sr = 0;
    longint p, ql, qr;
    for (int k = 0; k < NUM_CH; k++) begin
      p = longint'($signed(data[k*IN_W +: IN_W])) * longint'(gain[k*GAIN_W +: GAIN_W]);
      if (route[2*k])   sl += p;
      if (route[2*k+1]) sr += p;
    end
    ql = floor_div(sl, UNITY);
    qr = floor_div(sr, UNITY);
    e.cyc    = at;
    e.clip_l = (ql > 32767) || (ql < -32768);
    e.clip_r = (qr > 32767) || (qr < -32768);
    e.left   = (ql > 32767) ? 32767 : (ql < -32768) ? -32768 : int'(ql);
    e.right  = (qr > 32767) ? 32767 : (qr < -32768) ? -32768 : int'(qr);
    if (mute) begin
      e.left = 0; e.right = 0; e.clip_l = 1'b0; e.clip_r = 1'b0;
    end
    return e;
  endfunction

  // Compare every output frame against the oldest outstanding expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n && bus.valid_o) begin
      if (sb.size() == 0) begin
        check("spurious_valid", 1, 0);
      end else begin
        e = sb.pop_front();
        check("valid_cycle", cyc, e.cyc);
        check("left",   longint'($signed(bus.left_o)),  e.left);
        check("right",  longint'($signed(bus.right_o)), e.right);
        check("clip_l", bus.clip_l_o, e.clip_l);
        check("clip_r", bus.clip_r_o, e.clip_r);
      end
    end
  end

  task automatic set_ch(input int k, input int data, input int gain, input logic [1:0] route);
    d_data[k*IN_W +: IN_W]     = IN_W'(data);
    d_gain[k*GAIN_W +: GAIN_W] = GAIN_W'(gain);
    d_route[2*k +: 2]          = route;
  endtask

  task automatic apply(input bit push);
    bus.ch_data_i    = d_data;
    bus.ch_gain_i    = d_gain;
    bus.ch_route_i   = d_route;
    bus.mute_i       = d_mute;
    bus.sample_stb_i = 1'b1;
    if (push) sb.push_back(model(d_data, d_gain, d_route, d_mute, cyc + LAT));
  endtask

  task automatic strobe(input bit push, output int t);
    @(posedge clk); #1;
    t = cyc;
    apply(push);
    @(posedge clk); #1;
    bus.sample_stb_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || bus.busy_o) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("drain_timeout", n, 0);
  endtask

  task automatic set_unity();
    set_ch(0, 1000, 128, 2'b01);
    set_ch(1, -500, 128, 2'b10);
    set_ch(2, 2000, 128, 2'b01);
    set_ch(3, -700, 128, 2'b10);
  endtask

  task automatic solo(input int data, input int gain);
    set_ch(0, data, gain, 2'b11);
    set_ch(1, 12345, 200, 2'b00);
    set_ch(2, -9999, 255, 2'b00);
    set_ch(3, 31000, 77, 2'b00);
  endtask

  initial begin
    int t;
    n_checks = 0;
    n_pass   = 0;
    rst_n    = 1'b0;
    d_data = '0; d_gain = '0; d_route = '0; d_mute = 1'b0;
    bus.sample_stb_i = 1'b0; bus.ch_data_i = '0; bus.ch_gain_i = '0;
    bus.ch_route_i = '0; bus.mute_i = 1'b0; bus.clear_i = 1'b0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_left",    bus.left_o,    0);
    check("rst_right",   bus.right_o,   0);
    check("rst_valid",   bus.valid_o,   0);
    check("rst_busy",    bus.busy_o,    0);
    check("rst_clip",    {bus.clip_l_o, bus.clip_r_o}, 0);
    check("rst_overrun", bus.overrun_o, 0);
    @(posedge clk); #1 rst_n = 1'b1;

    // Unity mix with busy window T+1..T+5
    set_unity();
    strobe(1, t);
    repeat (LAT) begin
      @(negedge clk);
      check("busy_window", bus.busy_o, (cyc <= t + LAT - 1));
    end
    drain();
    check("unity_left",  longint'($signed(bus.left_o)),  3000);
    check("unity_right", longint'($signed(bus.right_o)), -1200);

    // Saturation, then a small frame clears the clip flags
    set_ch(0, 30000, 128, 2'b01);
    set_ch(1, -30000, 128, 2'b10);
    set_ch(2, 30000, 128, 2'b01);
    set_ch(3, -30000, 128, 2'b10);
    strobe(1, t); drain();
    check("sat_left",  longint'($signed(bus.left_o)),  32767);
    check("sat_right", longint'($signed(bus.right_o)), -32768);
    set_unity();
    strobe(1, t); drain();
    check("clip_cleared", {bus.clip_l_o, bus.clip_r_o}, 0);

    // Gain and floor rounding on a single routed channel
    solo(1000, 64);    strobe(1, t); drain();
    solo(-3, 64);      strobe(1, t); drain();
    check("floor_neg", longint'($signed(bus.left_o)), -2);
    solo(32767, 255);  strobe(1, t); drain();
    solo(-20000, 0);   strobe(1, t); drain();

    // Overrun: second strobe ignored, strobe on the valid cycle accepted
    set_unity();
    strobe(1, t);
    @(posedge clk); #1 bus.sample_stb_i = 1'b1;
    @(negedge clk); check("ovr_before", bus.overrun_o, 0);
    @(posedge clk); #1 bus.sample_stb_i = 1'b0;
    @(negedge clk); check("ovr_set", bus.overrun_o, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    @(negedge clk); check("ovr_sticky", bus.overrun_o, 1);
    @(posedge clk); #1;
    set_ch(0, 4321, 200, 2'b11);
    apply(1);
    @(posedge clk); #1 bus.sample_stb_i = 1'b0; bus.clear_i = 1'b1;
    @(negedge clk); check("ovr_hold", bus.overrun_o, 1);
    @(posedge clk); #1 bus.clear_i = 1'b0;
    @(negedge clk); check("ovr_cleared", bus.overrun_o, 0);
    drain();

    // Reset mid-frame abandons the frame
    strobe(0, t);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_left",  bus.left_o,  0);
    check("mid_rst_right", bus.right_o, 0);
    check("mid_rst_busy",  bus.busy_o,  0);
    @(posedge clk); #1;
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (LAT + 2) @(negedge clk);
    check("post_rst_busy",  bus.busy_o,  0);
    check("post_rst_valid", bus.valid_o, 0);
    set_unity();
    strobe(1, t); drain();

    // Mute at snapshot on a saturating frame
    set_ch(0, 30000, 255, 2'b11);
    d_mute = 1'b1;
    strobe(1, t); drain();
    d_mute = 1'b0;

    // Inputs changing during accumulation must not matter
    set_unity();
    strobe(1, t);
    bus.mute_i = 1'b1; bus.ch_data_i = '1; bus.ch_route_i = '0; bus.ch_gain_i = '0;
    drain();
    bus.mute_i = 1'b0;

    // Route 11 contributes to both sides
    solo(100, 128);
    strobe(1, t); drain();
    check("both_left",  longint'($signed(bus.left_o)),  100);
    check("both_right", longint'($signed(bus.right_o)), 100);

    // Random frames
    repeat (8) begin
      for (int k = 0; k < NUM_CH; k++)
        set_ch(k, int'($urandom_range(0, 65535)) - 32768, int'($urandom_range(0, 255)),
               2'($urandom_range(0, 3)));
      d_mute = ($urandom_range(0, 7) == 0);
      strobe(1, t); drain();
    end

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
